// File: rtl/edge_frame_sequencer_pkg.sv
// Shared types and window geometry for the Sobel frame sequencer.
package edge_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_CALC,
      S_WAIT,
      S_WRITE,
      S_CLEAR,
      S_DONE
   } seq_state_t;

   localparam int WIN_COLS = 4;
   localparam int WIN_STEP = 2;
   localparam int WIN_ROWS = 3;

endpackage

// File: rtl/edge_frame_sequencer_pos_counter.sv
// Row/column position of the 3x4 window, with last-column and last-row flags.
module edge_pos_counter
   import edge_seq_pkg::*;
#(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
) (
   input  logic                       clk,
   input  logic                       n_rst,
   input  logic                       clr,
   input  logic                       col_step,
   input  logic                       row_step,
   output logic [$clog2(IMG_H)-1:0]   row_idx,
   output logic [$clog2(IMG_W)-1:0]   col_idx,
   output logic                       col_last,
   output logic                       row_last
);

   localparam int COL_W = $clog2(IMG_W);
   localparam int ROW_W = $clog2(IMG_H);
   localparam logic [COL_W-1:0] COL_END = COL_W'(IMG_W - WIN_COLS);
   localparam logic [ROW_W-1:0] ROW_END = ROW_W'(IMG_H - WIN_ROWS);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         row_idx <= '0;
         col_idx <= '0;
      end else if (clr) begin
         row_idx <= '0;
         col_idx <= '0;
      end else if (row_step) begin
         row_idx <= row_idx + ROW_W'(1);
         col_idx <= '0;
      end else if (col_step) begin
         col_idx <= col_idx + COL_W'(WIN_STEP);
      end
   end

   assign col_last = (col_idx >= COL_END);
   assign row_last = (row_idx >= ROW_END);

endmodule

// File: rtl/edge_frame_sequencer.sv
// Frame scheduler for the Sobel window: column reads, buffer shifts, calc
// enables and result writes across an IMG_W x IMG_H image.
module edge_frame_sequencer
   import edge_seq_pkg::*;
#(
   parameter int IMG_W    = 640,
   parameter int IMG_H    = 480,
   parameter int CALC_LAT = 1
) (
   input  logic                       clk,
   input  logic                       n_rst,
   input  logic                       start,
   input  logic                       abort,
   output logic                       rd_req,
   input  logic                       rd_done,
   output logic                       shift_enable,
   output logic                       enable_calc,
   output logic                       wr_req,
   input  logic                       wr_done,
   output logic                       buffer_clear,
   output logic [$clog2(IMG_H)-1:0]   row_idx,
   output logic [$clog2(IMG_W)-1:0]   col_idx,
   output logic                       busy,
   output logic                       frame_done
);

   localparam int WAIT_W = (CALC_LAT > 1) ? $clog2(CALC_LAT) : 1;

   seq_state_t        state, state_nxt;
   logic [2:0]        need, need_nxt;
   logic [WAIT_W-1:0] wait_cnt, wait_nxt;
   logic              pos_clr, col_step, row_step;
   logic              col_last, row_last;
   logic              clear_nxt;

   edge_pos_counter #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H)
   ) u_pos (
      .clk      (clk),
      .n_rst    (n_rst),
      .clr      (pos_clr),
      .col_step (col_step),
      .row_step (row_step),
      .row_idx  (row_idx),
      .col_idx  (col_idx),
      .col_last (col_last),
      .row_last (row_last)
   );

   // Outputs are registered from the next state, so each one is valid
   // in the same cycle the machine sits in the matching state.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state        <= S_IDLE;
         need         <= '0;
         wait_cnt     <= '0;
         rd_req       <= 1'b0;
         shift_enable <= 1'b0;
         enable_calc  <= 1'b0;
         wr_req       <= 1'b0;
         buffer_clear <= 1'b0;
         busy         <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         state        <= state_nxt;
         need         <= need_nxt;
         wait_cnt     <= wait_nxt;
         rd_req       <= (state_nxt == S_LOAD);
         shift_enable <= (state_nxt == S_SHIFT);
         enable_calc  <= (state_nxt == S_CALC);
         wr_req       <= (state_nxt == S_WRITE);
         buffer_clear <= clear_nxt;
         busy         <= (state_nxt != S_IDLE);
         frame_done   <= (state_nxt == S_DONE);
      end
   end

   always_comb begin
      state_nxt = state;
      need_nxt  = need;
      wait_nxt  = wait_cnt;
      pos_clr   = 1'b0;
      col_step  = 1'b0;
      row_step  = 1'b0;
      clear_nxt = 1'b0;
      if (state != S_IDLE && abort) begin
         state_nxt = S_IDLE;
         need_nxt  = '0;
         pos_clr   = 1'b1;
         clear_nxt = 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               if (start && !abort) begin
                  state_nxt = S_LOAD;
                  need_nxt  = 3'(WIN_COLS);
                  pos_clr   = 1'b1;
               end
            end
            S_LOAD: begin
               if (rd_done) begin
                  need_nxt  = need - 3'd1;
                  state_nxt = S_SHIFT;
               end
            end
            S_SHIFT: state_nxt = (need != '0) ? S_LOAD : S_CALC;
            S_CALC: begin
               state_nxt = S_WAIT;
               wait_nxt  = WAIT_W'(CALC_LAT - 1);
            end
            S_WAIT: begin
               if (wait_cnt == '0) state_nxt = S_WRITE;
               else                wait_nxt  = wait_cnt - WAIT_W'(1);
            end
            S_WRITE: begin
               if (wr_done) begin
                  if (!col_last) begin
                     col_step  = 1'b1;
                     need_nxt  = 3'(WIN_STEP);
                     state_nxt = S_LOAD;
                  end else if (!row_last) begin
                     row_step  = 1'b1;
                     state_nxt = S_CLEAR;
                  end else begin
                     state_nxt = S_DONE;
                  end
               end
            end
            S_CLEAR: begin
               need_nxt  = 3'(WIN_COLS);
               state_nxt = S_LOAD;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
         if (state_nxt == S_CLEAR) clear_nxt = 1'b1;
      end
   end

endmodule
